// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and default widths for the sequential ALU.
package alu_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int CTRL_W_DEF = 3;

    localparam logic [CTRL_W_DEF-1:0] OP_ADD = 3'b000;
    localparam logic [CTRL_W_DEF-1:0] OP_MUL = 3'b001;
    localparam logic [CTRL_W_DEF-1:0] OP_SUB = 3'b010;
    localparam logic [CTRL_W_DEF-1:0] OP_AND = 3'b011;
    localparam logic [CTRL_W_DEF-1:0] OP_OR  = 3'b100;
    localparam logic [CTRL_W_DEF-1:0] OP_XOR = 3'b101;
    localparam logic [CTRL_W_DEF-1:0] OP_SLT = 3'b110;
    localparam logic [CTRL_W_DEF-1:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   sum_s;

    // lo_q starts as the multiplier and is shifted out while product bits shift in from the top
    always_comb begin
        sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start_i) begin
            mcand_d = a_i;
            hi_d    = {WIDTH{1'b0}};
            lo_d    = b_i;
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b1;
        end else if (busy_q) begin
            hi_d = sum_s[WIDTH:1];
            lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
            if (cnt_q == CNT_W'(WIDTH-1)) begin
                cnt_d  = {CNT_W{1'b0}};
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = {hi_q, lo_q};

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready handshake, single-cycle logic/arithmetic ops and an iterative MUL.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  data1_i,
    input  logic [WIDTH-1:0]  data2_i,
    input  logic [CTRL_W-1:0] ALUCtrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  data_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic              Zero_o,
    output logic              ovf_o,
    output logic              busy_o
);

    localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(OP_ADD);
    localparam logic [CTRL_W-1:0] C_MUL = CTRL_W'(OP_MUL);
    localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(OP_SUB);
    localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(OP_AND);
    localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(OP_OR);
    localparam logic [CTRL_W-1:0] C_XOR = CTRL_W'(OP_XOR);
    localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(OP_SLT);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               mul_zero_q, mul_zero_d;

    logic               accept_s;
    logic               mul_start_s;
    logic               mul_busy_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic [WIDTH-1:0]   b_neg_s;
    logic [WIDTH-1:0]   add_s;
    logic [WIDTH-1:0]   sub_s;
    logic               zero_s;
    logic               add_ovf_s;
    logic               sub_ovf_s;
    logic [WIDTH-1:0]   res_s;
    logic               ovf_s;

    assign accept_s = in_valid_i & (state_q == ST_IDLE);

    // Single-cycle datapath evaluated on the live inputs; only sampled at the accept edge
    always_comb begin
        b_neg_s   = ~data2_i + WIDTH'(1);
        add_s     = data1_i + data2_i;
        sub_s     = data1_i + b_neg_s;
        zero_s    = (sub_s == {WIDTH{1'b0}});
        add_ovf_s = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) & (add_s[WIDTH-1] != data1_i[WIDTH-1]);
        sub_ovf_s = (data1_i[WIDTH-1] == b_neg_s[WIDTH-1]) & (sub_s[WIDTH-1] != data1_i[WIDTH-1]);
        res_s     = {WIDTH{1'b0}};
        ovf_s     = 1'b0;
        case (ALUCtrl_i)
            C_ADD: begin
                res_s = add_s;
                ovf_s = add_ovf_s;
            end
            C_SUB: begin
                res_s = sub_s;
                ovf_s = sub_ovf_s;
            end
            C_AND:   res_s = data1_i & data2_i;
            C_OR:    res_s = data1_i | data2_i;
            C_XOR:   res_s = data1_i ^ data2_i;
            C_SLT:   res_s = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state and result-register update
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        mul_zero_d  = mul_zero_q;
        mul_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (ALUCtrl_i == C_MUL) begin
                        state_d     = ST_MUL;
                        mul_start_s = 1'b1;
                        mul_zero_d  = zero_s;
                    end else begin
                        state_d = ST_DONE;
                        data_d  = res_s;
                        hi_d    = {WIDTH{1'b0}};
                        zero_d  = zero_s;
                        ovf_d   = ovf_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d = ST_DONE;
                    data_d  = mul_prod_s[WIDTH-1:0];
                    hi_d    = mul_prod_s[2*WIDTH-1:WIDTH];
                    zero_d  = mul_zero_q;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and result registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            data_q     <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            mul_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            hi_q       <= hi_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            mul_zero_q <= mul_zero_d;
        end
    end

    seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start_s),
        .a_i       (data1_i),
        .b_i       (data2_i),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
    );

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = mul_busy_s;
    assign data_o      = data_q;
    assign hi_o        = hi_q;
    assign Zero_o      = zero_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for latency-1 ops plus hand sequences for MUL, backpressure and reset.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] d1, d2, dout, hout;
    logic [2:0]  op;
    logic        zero, ovf, busy;

    logic        e_valid, e_ready, e_ovalid, e_oready;
    logic [7:0]  e_d1, e_d2, e_data, e_hi;
    logic [2:0]  e_op;
    logic        e_zero, e_ovf, e_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[12];

    seq_alu #(.WIDTH(32), .CTRL_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data1_i(d1), .data2_i(d2), .ALUCtrl_i(op), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .data_o(dout), .hi_o(hout), .Zero_o(zero),
        .ovf_o(ovf), .busy_o(busy)
    );

    seq_alu #(.WIDTH(8), .CTRL_W(3)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(e_valid), .in_ready_o(e_ready),
        .data1_i(e_d1), .data2_i(e_d2), .ALUCtrl_i(e_op), .out_valid_o(e_ovalid),
        .out_ready_i(e_oready), .data_o(e_data), .hi_o(e_hi), .Zero_o(e_zero),
        .ovf_o(e_ovf), .busy_o(e_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 32-bit MUL: check latency, busy duration, product and flags, then return to IDLE
    task automatic mul_run(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic ez);
        int cyc;
        int bcnt;
        int rdy;
        d1 = a; d2 = b; op = 3'b001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; d1 = 32'hDEAD_BEEF; d2 = 32'h0BAD_F00D; op = 3'b000;
        cyc = 0; bcnt = 0; rdy = 0;
        while (!out_valid && cyc < 100) begin
            if (busy) bcnt++;
            if (in_ready) rdy++;
            tick();
            cyc++;
        end
        chk("mul_latency", 64'(cyc), 64'd33);
        chk("mul_busy_cycles", 64'(bcnt), 64'd32);
        chk("mul_ready_low", 64'(rdy), 64'd0);
        chk("mul_hi", 64'(hout), 64'(ehi));
        chk("mul_lo", 64'(dout), 64'(elo));
        chk("mul_zero", 64'(zero), 64'(ez));
        chk("mul_ovf", 64'(ovf), 64'd0);
        tick();
        chk("mul_valid_drop", 64'(out_valid), 64'd0);
        chk("mul_ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        int cyc;
        vecs[0]  = '{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[1]  = '{3'b010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
        vecs[3]  = '{3'b101, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5]  = '{3'b011, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0};
        vecs[6]  = '{3'b100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0};
        vecs[7]  = '{3'b010, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[8]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[10] = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
        vecs[11] = '{3'b010, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; d1 = '0; d2 = '0; op = '0;
        e_valid = 1'b0; e_oready = 1'b1; e_d1 = '0; e_d2 = '0; e_op = '0;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(dout), 64'd0);
        chk("rst_hi", 64'(hout), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_ready_after", 64'(in_ready), 64'd1);

        foreach (vecs[i]) begin
            d1 = vecs[i].a; d2 = vecs[i].b; op = vecs[i].op; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_data", i), 64'(dout), 64'(vecs[i].res));
            chk($sformatf("v%0d_hi", i), 64'(hout), 64'd0);
            chk($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].z));
            chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].v));
            tick();
            chk($sformatf("v%0d_idle", i), 64'(in_ready), 64'd1);
            chk($sformatf("v%0d_vdrop", i), 64'(out_valid), 64'd0);
        end

        mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        mul_run(32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1);
        mul_run(32'h0000_0003, 32'h0000_0007, 32'h0000_0000, 32'h0000_0015, 1'b0);

        // Backpressure: SUB held 10 cycles while a pending ADD is presented and must be ignored
        out_ready = 1'b0;
        d1 = 32'd5; d2 = 32'd5; op = 3'b010; in_valid = 1'b1;
        tick();
        d1 = 32'd1; d2 = 32'd2; op = 3'b000;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d_data", c), 64'(dout), 64'd0);
            chk($sformatf("bp%0d_zero", c), 64'(zero), 64'd1);
            chk($sformatf("bp%0d_ready", c), 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_idle", 64'(in_ready), 64'd1);
        chk("bp_vdrop", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_data", 64'(dout), 64'd3);
        tick();

        // Reset in the middle of a multiply
        d1 = 32'hFFFF_FFFF; d2 = 32'd3; op = 3'b001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("mr_busy_before", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_data", 64'(dout), 64'd0);
        chk("mr_hi", 64'(hout), 64'd0);
        chk("mr_zero", 64'(zero), 64'd0);
        chk("mr_ovf", 64'(ovf), 64'd0);
        tick();
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mr_no_valid", 64'(seen), 64'd0);
        d1 = 32'd2; d2 = 32'd3; op = 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_add_valid", 64'(out_valid), 64'd1);
        chk("mr_add_data", 64'(dout), 64'd5);
        tick();

        // WIDTH=8 instance
        chk("w8_ready", 64'(e_ready), 64'd1);
        e_d1 = 8'hFF; e_d2 = 8'h02; e_op = 3'b001; e_valid = 1'b1;
        tick();
        e_valid = 1'b0;
        cyc = 0;
        while (!e_ovalid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("w8_mul_latency", 64'(cyc), 64'd9);
        chk("w8_mul_hi", 64'(e_hi), 64'h01);
        chk("w8_mul_lo", 64'(e_data), 64'hFE);
        chk("w8_mul_zero", 64'(e_zero), 64'd0);
        tick();
        e_d1 = 8'h7F; e_d2 = 8'h01; e_op = 3'b000; e_valid = 1'b1;
        tick();
        e_valid = 1'b0;
        chk("w8_add_valid", 64'(e_ovalid), 64'd1);
        chk("w8_add_data", 64'(e_data), 64'h80);
        chk("w8_add_ovf", 64'(e_ovf), 64'd1);
        chk("w8_add_hi", 64'(e_hi), 64'd0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 Parameter CTRL_W, default 3, opcode width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 in_valid_i  input  1  operand/opcode present.
REQ-006 in_ready_o  output  1  block accepts an operation this cycle.
REQ-007 data1_i  input  WIDTH  operand A.
REQ-008 data2_i  input  WIDTH  operand B.
REQ-009 ALUCtrl_i  input  CTRL_W  opcode.
REQ-010 out_valid_o  output  1  result registers hold a valid result.
REQ-011 out_ready_i  input  1  consumer takes result this cycle.
REQ-012 data_o  output  WIDTH  result, low half for MUL.
REQ-013 hi_o  output  WIDTH  upper product half for MUL; 0 for all other ops.
REQ-014 Zero_o  output  1  1 when captured data1_i - data2_i == 0, for every opcode.
REQ-015 ovf_o  output  1  signed overflow for ADD/SUB; 0 for all other ops.
REQ-016 busy_o  output  1  1 while in MUL state.

Function
REQ-017 Opcodes: ADD 000, MUL 001, SUB 010, AND 011, OR 100, XOR 101, SLT 110 (signed A<B -> 1 else 0), 111 -> result 0, flags 0 except Zero_o.
REQ-018 Accept = in_valid_i & in_ready_o; operands and opcode are registered at accept; later input changes have no effect.
REQ-019 FSM states IDLE, MUL, DONE; in_ready_o = 1 only in IDLE.
REQ-020 IDLE + accept of non-MUL op -> DONE; out_valid_o high the next cycle (latency 1).
REQ-021 IDLE + accept of MUL -> MUL; unsigned shift-add, one bit per cycle, exactly WIDTH cycles, then DONE; out_valid_o rises WIDTH+1 cycles after accept.
REQ-022 MUL result is the full 2*WIDTH unsigned product: {hi_o, data_o}; no truncation.
REQ-023 ADD/SUB wrap modulo 2^WIDTH; ovf_o = sign(A)==sign(B') & sign(result)!=sign(A), with B' = B for ADD, ~B+1 for SUB.
REQ-024 DONE: data_o, hi_o, Zero_o, ovf_o held stable while out_valid_o & ~out_ready_i (backpressure, unlimited).
REQ-025 DONE & out_ready_i -> IDLE; out_valid_o low the next cycle; no same-cycle re-accept (one op in flight, max throughput one op per 2 cycles).
REQ-026 in_valid_i while not IDLE is ignored and not queued; the producer keeps it asserted.
REQ-027 Result outputs retain last values in IDLE/MUL; only out_valid_o qualifies them.
REQ-028 Unused opcode never stalls; behaves as latency-1 op.

Reset
REQ-029 rst_i low asynchronously forces state IDLE, out_valid_o 0, busy_o 0, data_o 0, hi_o 0, Zero_o 0, ovf_o 0, multiplier accumulator/counter 0.
REQ-030 in_ready_o is 1 in the first cycle after rst_i deasserts.
REQ-031 Reset mid-MUL or mid-DONE discards the operation; no out_valid_o pulse follows.

Structure
REQ-032 Package alu_pkg holds opcode constants (CTRL_W-wide), FSM state typedef, and the WIDTH default.
REQ-033 Iterative multiplier is sub-module seq_mul (start, done, WIDTH-parametrised, 2*WIDTH product); seq_alu holds FSM, handshake, and single-cycle ops.
REQ-034 No combinational path from in_valid_i or out_ready_i to any output other than in_ready_o/state-derived signals.

Verification
REQ-035 WIDTH=32, ADD 0x7FFFFFFF+1, out_ready_i=1 -> next cycle data_o=0x80000000, ovf_o=1, Zero_o=0.
REQ-036 WIDTH=32, MUL 0xFFFFFFFF*0xFFFFFFFF -> out_valid_o exactly 33 cycles after accept, hi_o=0xFFFFFFFE, data_o=0x00000001, busy_o high 32 cycles.
REQ-037 SUB 5-5 with out_ready_i=0 for 10 cycles -> data_o=0, Zero_o=1 held stable all 10 cycles, in_ready_o=0 throughout, IDLE one cycle after out_ready_i=1.
REQ-038 SLT -1 vs 1 -> data_o=1; XOR 0xF0F0 ^ 0x0FF0 -> 0xFF00; opcode 111 -> data_o=0, hi_o=0.
REQ-039 Assert rst_i low at MUL cycle 10 -> all outputs 0 immediately, no out_valid_o afterwards, new ADD after release completes with latency 1.
REQ-040 WIDTH=8, MUL 0xFF*0x02 -> out_valid_o 9 cycles after accept, hi_o=0x01, data_o=0xFE.
